// File: rtl/motor_pkg.sv
// Shared types and default sizing for the motor command scheduler.
// The optional preemption feature is selected by MOTOR_SCHED_PREEMPT_EN.
package motor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_CYC_W       = 24;
  localparam int DEF_PWM_W       = 32;
  localparam int DEF_DEAD_CYCLES = 16;

endpackage

// File: rtl/motor_rr_arbiter.sv
// Round-robin picker: first valid requester at or after ptr, wrapping at NUM_REQ.
module motor_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any
);

  int idx_s;

  // scan requesters starting at the pointer; first hit wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx_s     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = (int'(ptr) + k) % NUM_REQ;
      if (!any && req_valid[idx_s]) begin
        any            = 1'b1;
        grant[idx_s]   = 1'b1;
        grant_idx      = IDW'(idx_s);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/motor_cmd_scheduler.sv
// Shares one motor driver between NUM_REQ requesters with round-robin arbitration and a
// pwm=0 dead time before direction reversals. Define MOTOR_SCHED_PREEMPT_EN to let requester 0 preempt.
module motor_cmd_scheduler
  import motor_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int CYC_W       = DEF_CYC_W,
  parameter int PWM_W       = DEF_PWM_W,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic                       Motor_Clk,
  input  logic                       Motor_Rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_dir,
  input  logic [NUM_REQ*PWM_W-1:0]   req_pwm,
  input  logic [NUM_REQ*CYC_W-1:0]   req_cycles,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         done,
  output logic                       abort,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       mot_direction,
  output logic [PWM_W-1:0]           mot_pwm,
  output logic [31:0]                mot_pulse_num
);

  localparam int IDW = $clog2(NUM_REQ);

  state_e             state_r, state_s;
  logic [IDW-1:0]     rr_ptr_r, arb_idx_s, grant_s;
  logic [NUM_REQ-1:0] arb_onehot_s;
  logic               arb_any_s;
  logic               accept_s, preempt_s;
  logic               dir_r, last_dir_r, has_run_r;
  logic [PWM_W-1:0]   pwm_r;
  logic [CYC_W-1:0]   cycles_r, cnt_r;
  logic               sel_dir_s, run_dir_s;
  logic [PWM_W-1:0]   sel_pwm_s, run_pwm_s;
  logic [CYC_W-1:0]   sel_cyc_s, run_cyc_s;

  motor_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req_valid (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (arb_onehot_s),
    .grant_idx (arb_idx_s),
    .any       (arb_any_s)
  );

  assign sel_dir_s = req_dir[arb_idx_s];
  assign sel_pwm_s = req_pwm[int'(arb_idx_s)*PWM_W +: PWM_W];
  assign sel_cyc_s = req_cycles[int'(arb_idx_s)*CYC_W +: CYC_W];
  assign req_ready = (state_r == S_IDLE) ? arb_onehot_s : '0;

  // On the accept cycle the command is not captured yet, so take it straight from the inputs.
  assign run_dir_s = accept_s ? sel_dir_s : dir_r;
  assign run_pwm_s = accept_s ? sel_pwm_s : pwm_r;
  assign run_cyc_s = accept_s ? sel_cyc_s : cycles_r;
  assign grant_s   = accept_s ? arb_idx_s : grant_id;

  // next-state decode
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    preempt_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (arb_any_s) begin
          accept_s = 1'b1;
          if (sel_pwm_s == '0 || sel_cyc_s == '0) begin
            state_s = S_DONE;
          end else if (has_run_r && (sel_dir_s != last_dir_r)) begin
            state_s = S_DEAD;
          end else begin
            state_s = S_RUN;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DEAD:  state_s = (cnt_r == CYC_W'(1)) ? S_RUN : S_DEAD;
      S_RUN:   state_s = (cnt_r == CYC_W'(1)) ? S_DONE : S_RUN;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
`ifdef MOTOR_SCHED_PREEMPT_EN
    if ((state_r == S_DEAD || state_r == S_RUN) && grant_id != '0 && req_valid[0]) begin
      preempt_s = 1'b1;
      state_s   = S_DONE;
    end else begin
      preempt_s = 1'b0;
    end
`endif
  end

  // state, captured command, counters and registered motor outputs
  always_ff @(posedge Motor_Clk or negedge Motor_Rst_n) begin
    if (!Motor_Rst_n) begin
      state_r       <= S_IDLE;
      rr_ptr_r      <= '0;
      grant_id      <= '0;
      dir_r         <= 1'b0;
      pwm_r         <= '0;
      cycles_r      <= '0;
      cnt_r         <= '0;
      last_dir_r    <= 1'b0;
      has_run_r     <= 1'b0;
      done          <= '0;
      abort         <= 1'b0;
      busy          <= 1'b0;
      mot_direction <= 1'b0;
      mot_pwm       <= '0;
      mot_pulse_num <= 32'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        grant_id <= arb_idx_s;
        dir_r    <= sel_dir_s;
        pwm_r    <= sel_pwm_s;
        cycles_r <= sel_cyc_s;
      end
      if (state_s == S_DEAD && state_r != S_DEAD) begin
        cnt_r <= CYC_W'(DEAD_CYCLES);
      end else if (state_s == S_RUN && state_r != S_RUN) begin
        cnt_r <= run_cyc_s;
      end else if (state_r == S_DEAD || state_r == S_RUN) begin
        cnt_r <= cnt_r - CYC_W'(1);
      end
      if (state_s == S_RUN) begin
        mot_direction <= run_dir_s;
        mot_pwm       <= run_pwm_s;
        mot_pulse_num <= 32'(run_cyc_s);
      end else begin
        mot_pwm       <= '0;
        mot_pulse_num <= 32'd0;
      end
      if (state_s == S_RUN && state_r != S_RUN) begin
        last_dir_r <= run_dir_s;
        has_run_r  <= 1'b1;
      end
      done  <= (state_s == S_DONE) ? (NUM_REQ'(1) << grant_s) : '0;
      abort <= preempt_s;
      busy  <= (state_s != S_IDLE);
      // abort is only ever high during DONE, so it doubles as the "preempted" marker here
      if (state_r == S_DONE) begin
        if (abort || grant_id == IDW'(NUM_REQ - 1)) begin
          rr_ptr_r <= '0;
        end else begin
          rr_ptr_r <= grant_id + IDW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Randomized and directed bench for motor_cmd_scheduler against a timeline model of each command.
// Build with MOTOR_SCHED_PREEMPT_EN defined to also exercise preemption.
module tb_motor_cmd_scheduler;

  localparam int N   = 2;
  localparam int PW  = 32;
  localparam int CW  = 24;
  localparam int DC  = 16;
  localparam int BIG = 1 << 30;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_dir = '0;
  logic [N*PW-1:0]  req_pwm = '0;
  logic [N*CW-1:0]  req_cycles = '0;
  logic [N-1:0]     req_ready, done;
  logic             abort, busy;
  logic [0:0]       grant_id;
  logic             mot_direction;
  logic [PW-1:0]    mot_pwm;
  logic [31:0]      mot_pulse_num;

  motor_cmd_scheduler #(.NUM_REQ(N), .CYC_W(CW), .PWM_W(PW), .DEAD_CYCLES(DC)) dut (
    .Motor_Clk     (clk),
    .Motor_Rst_n   (rst_n),
    .req_valid     (req_valid),
    .req_dir       (req_dir),
    .req_pwm       (req_pwm),
    .req_cycles    (req_cycles),
    .req_ready     (req_ready),
    .done          (done),
    .abort         (abort),
    .busy          (busy),
    .grant_id      (grant_id),
    .mot_direction (mot_direction),
    .mot_pwm       (mot_pwm),
    .mot_pulse_num (mot_pulse_num)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model: one timeline per accepted command (accept, run window, done cycle).
  int          m_acc, m_rs, m_re, m_done, m_free, m_abort, m_rr, m_grant, m_gid_prev;
  logic        m_has_run, m_last_dir, m_cdir, m_dir_before, m_dir_after;
  logic [31:0] m_cpwm;
  logic [23:0] m_ccyc;
  logic [N-1:0] rdy_q, done_q;
  logic        abort_q, prev_dir;
  logic [31:0] prev_pwm;
  int          acc_cyc, done_cyc;

  task automatic model_reset();
    m_acc = -10; m_rs = -10; m_re = -11; m_done = -10; m_free = 0; m_abort = -10;
    m_rr = 0; m_grant = 0; m_gid_prev = 0;
    m_has_run = 1'b0; m_last_dir = 1'b0; m_cdir = 1'b0; m_dir_before = 1'b0; m_dir_after = 1'b0;
    m_cpwm = '0; m_ccyc = '0;
    rdy_q = '0; done_q = '0; abort_q = 1'b0; prev_dir = 1'b0; prev_pwm = '0;
  endtask

  always @(negedge clk) begin
    int          w;
    logic        dead, exp_dir, in_run;
    logic [N-1:0] exp_rdy;
    if (!rst_n) begin
      model_reset();
    end else begin
      rdy_q = req_ready; done_q = done; abort_q = abort;
      if (|req_ready) acc_cyc = cyc;
      if (|done) done_cyc = cyc;
      if (cyc == m_rs) begin
        m_has_run = 1'b1;
        m_last_dir = m_cdir;
      end
      in_run  = (cyc >= m_rs) && (cyc <= m_re);
      exp_dir = (cyc >= m_rs) ? m_dir_after : m_dir_before;
      w = -1;
      exp_rdy = '0;
      if (cyc >= m_free) begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      check_val("ready", req_ready, exp_rdy);
      check_val("pwm", mot_pwm, in_run ? m_cpwm : 32'd0);
      check_val("pulse_num", mot_pulse_num, in_run ? 32'(m_ccyc) : 32'd0);
      check_val("done", done, (cyc == m_done) ? (64'd1 << m_grant) : 64'd0);
      check_val("busy", busy, (cyc > m_acc) && (cyc <= m_done));
      check_val("direction", mot_direction, exp_dir);
      check_val("grant_id", grant_id, (cyc > m_acc) ? m_grant : m_gid_prev);
      check_val("abort", abort, cyc == m_abort);
      if (mot_direction != prev_dir) check_val("dir_while_pwm", prev_pwm, 0);
      prev_dir = mot_direction;
      prev_pwm = mot_pwm;
`ifdef MOTOR_SCHED_PREEMPT_EN
      if (cyc > m_acc && cyc < m_done && m_grant != 0 && req_valid[0]) begin
        if (cyc < m_rs) begin
          m_rs = BIG; m_re = BIG - 1;
        end else begin
          m_re = cyc;
        end
        m_done = cyc + 1; m_abort = cyc + 1; m_free = cyc + 2; m_rr = 0;
      end
`endif
      if (w >= 0) begin
        m_gid_prev = (cyc > m_acc) ? m_grant : m_gid_prev;
        m_grant = w; m_acc = cyc;
        m_cdir = req_dir[w];
        m_cpwm = req_pwm[w*PW +: PW];
        m_ccyc = req_cycles[w*CW +: CW];
        m_dir_before = exp_dir;
        m_dir_after  = exp_dir;
        if (m_cpwm == 0 || m_ccyc == 0) begin
          m_rs = BIG; m_re = BIG - 1; m_done = cyc + 1;
        end else begin
          dead = m_has_run && (m_cdir != m_last_dir);
          m_rs = cyc + 1 + (dead ? DC : 0);
          m_re = m_rs + int'(m_ccyc) - 1;
          m_done = m_re + 1;
          m_dir_after = m_cdir;
        end
        m_free = m_done + 1;
        m_rr = (w + 1) % N;
      end
    end
  end

  bit hold_mode = 1'b0;
  bit rand_en = 1'b0;

  task automatic set_req(input int i, input logic d, input logic [31:0] p, input logic [23:0] n);
    req_valid[i] = 1'b1;
    req_dir[i] = d;
    req_pwm[i*PW +: PW] = p;
    req_cycles[i*CW +: CW] = n;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rdy_q[i] && !hold_mode) req_valid[i] = 1'b0;
      if (rand_en && !req_valid[i] && $urandom_range(0, 3) == 0)
        set_req(i, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000)),
                ($urandom_range(0, 9) == 0) ? 24'd0 : 24'($urandom_range(1, 12)));
    end
  endtask

  task automatic wait_ready(input string tag, input int i, output bit got);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      step();
      got = rdy_q[i];
    end
    if (!got) check_val({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string tag, output bit got);
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      step();
      got = |done_q;
    end
    if (!got) check_val({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic run_cmd(input string tag, input int i, input logic d, input logic [31:0] p,
                         input logic [23:0] n, input int lat);
    bit got;
    set_req(i, d, p, n);
    wait_ready(tag, i, got);
    if (got) begin
      wait_done(tag, got);
      if (got) begin
        check_val({tag, "_latency"}, done_cyc - acc_cyc, lat);
        check_val({tag, "_owner"}, done_q, 64'd1 << i);
      end
    end
  endtask

  initial begin
    bit got;
    int prev_w, w, cnt;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_pwm", mot_pwm, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_dir", mot_direction, 0);
    check_val("rst_pulse", mot_pulse_num, 0);
    rst_n = 1'b1;

    run_cmd("t2_single", 0, 1'b0, 32'd100, 24'd10, 11);
    run_cmd("t3_same_dir", 0, 1'b0, 32'd80, 24'd5, 6);
    run_cmd("t3_reverse", 0, 1'b1, 32'd80, 24'd5, 1 + DC + 5);
    run_cmd("t5_zero_pwm", 1, 1'b0, 32'd0, 24'd20, 1);
    run_cmd("t5_zero_cyc", 0, 1'b0, 32'd55, 24'd0, 1);

    // both requesters continuously valid: grants must alternate
    hold_mode = 1'b1;
    set_req(0, 1'b1, 32'd50, 24'd3);
    set_req(1, 1'b1, 32'd60, 24'd3);
    prev_w = -1; cnt = 0;
    for (int k = 0; k < 300 && cnt < 6; k++) begin
      step();
      if (|rdy_q) begin
        w = rdy_q[1] ? 1 : 0;
        if (prev_w >= 0) check_val("t4_alternate", w, 1 - prev_w);
        prev_w = w;
        cnt++;
      end
    end
    check_val("t4_grants", cnt, 6);
    hold_mode = 1'b0;
    req_valid = '0;
    repeat (40) step();

`ifdef MOTOR_SCHED_PREEMPT_EN
    set_req(1, 1'b1, 32'd7, 24'd100);
    wait_ready("t6", 1, got);
    repeat (30) step();
    set_req(0, 1'b1, 32'd9, 24'd4);
    wait_done("t6", got);
    check_val("t6_done_owner", done_q, 2'b10);
    check_val("t6_abort", abort_q, 1);
    wait_ready("t6_next", 0, got);
    repeat (30) step();
`endif

    // reset in the middle of a reversing run
    set_req(1, 1'b0, 32'd500, 24'd50);
    wait_ready("t1", 1, got);
    repeat (25) step();
    check_val("t1_pwm_running", mot_pwm, 500);
    #3;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check_val("t1_pwm_async", mot_pwm, 0);
    check_val("t1_busy", busy, 0);
    check_val("t1_grant", grant_id, 0);
    check_val("t1_dir", mot_direction, 0);
    check_val("t1_pulse", mot_pulse_num, 0);
    check_val("t1_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cmd("t1_after", 0, 1'b1, 32'd3, 24'd2, 3);

    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    req_valid = '0;
    repeat (60) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
